// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline of the 16-bit CPU:
// default widths, the bubble and match instruction encodings, and the
// packed beat carried between the stages.
package pipe_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF   = 16'h0800;
  localparam logic [INSTR_W_DEF-1:0] MATCH_INSTR_DEF = 16'h4F02;

  // One pipeline beat at default widths: PC in the upper bits, instruction below.
  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } beat_t;

endpackage

// File: rtl/skid_slot.sv
// One storage slot of the IF/ID skid buffer: a valid flag plus a beat
// register. clear wins over load. State updates on the falling clock edge.
module skid_slot
  import pipe_pkg::*;
#(
  parameter type slot_t = beat_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  slot_t d,
  output logic  valid,
  output slot_t q
);

  // Valid flag: cleared by reset or clear, set by load.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Beat payload: captured on load, otherwise held.
  // NOTE: the payload has no reset; it is only ever observed while valid is set.
  always_ff @(negedge clk) begin
    if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a two-entry skid buffer (main + skid slots).
// in_ready comes straight from the skid valid register, so there is no
// combinational path from out_ready to in_ready. State updates on the
// falling clock edge; rst is asynchronous and active low.
// Optional feature macro: PERF_MATCH_CNT_EN enables the match counter;
// without it match_cnt is tied to zero.
module if_id_skid
  import pipe_pkg::*;
#(
  parameter int                 PC_W        = PC_W_DEF,
  parameter int                 INSTR_W     = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = INSTR_W'(NOP_INSTR_DEF),
  parameter logic [INSTR_W-1:0] MATCH_INSTR = INSTR_W'(MATCH_INSTR_DEF),
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [7:0]         led_a,
  output logic [7:0]         led_b
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } stage_beat_t;

  stage_beat_t in_beat, main_d, main_beat, skid_beat;
  logic        main_valid, skid_valid;
  logic        accept, consume;
  logic        main_load, main_clear, skid_load, skid_clear;

  assign in_beat  = '{pc: pc_in, instr: instr_in};
  assign in_ready = !skid_valid;

  // Handshake decode and slot steering; flush overrides every handshake.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept     = 1'b0;
    consume    = 1'b0;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = skid_valid ? skid_beat : in_beat;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      accept  = in_valid && !skid_valid;
      consume = main_valid && out_ready;
      // Main refills when free or draining: older skid beat first, else the new beat.
      main_load  = (!main_valid || consume) && (skid_valid || accept);
      main_clear = consume && !skid_valid && !accept;
      // A new beat parks in skid only when main stays occupied.
      skid_load  = accept && main_valid && !consume;
      skid_clear = consume && skid_valid;
    end
  end

  skid_slot #(.slot_t(stage_beat_t)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_beat)
  );

  skid_slot #(.slot_t(stage_beat_t)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_beat),
    .valid (skid_valid),
    .q     (skid_beat)
  );

  // Presented beat: a bubble whenever main is empty, hiding stale payload.
  always_comb begin
    out_valid = main_valid;
    pc_out    = '0;
    instr_out = NOP_INSTR;
    if (main_valid) begin
      pc_out    = main_beat.pc;
      instr_out = main_beat.instr;
    end
  end

  assign led_a = instr_out[INSTR_W-1 -: 8];
  assign led_b = pc_out[7:0];

`ifdef PERF_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Wrapping count of accepted beats carrying MATCH_INSTR.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (accept && (instr_in == MATCH_INSTR)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_match;

  assign unused_match = (instr_in == MATCH_INSTR);
  assign match_cnt    = '0;
`endif

endmodule
